// File: rtl/result_collector_pkg.sv
// Shared constants and state encoding for the result collector.
// Word layout is {ERR, data[DW-1:0]}.
package result_collector_pkg;

  localparam int DW         = 6;
  localparam int AW         = 4;
  localparam int WORD_WIDTH = DW + 1;
  localparam int RAM_DEPTH  = 2 ** AW;
  localparam int ERR_BIT    = WORD_WIDTH - 1;

  localparam logic [AW-1:0] LAST_IDX = AW'(RAM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_EVAL  = 3'd4,
    REPORT   = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/result_collector_ram.sv
// Single-port RAM: synchronous write, 1-cycle registered read.
// Contents are never cleared; rdata holds until the next read.
module result_collector_ram #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  en,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
    if (en && re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/result_collector.sv
// Captures one frame of result words, then reads it back and
// reports every flagged word over a valid/ready handshake.
module result_collector
  import result_collector_pkg::*;
(
  input  logic                  i_clk_top,
  input  logic                  i_rst_top,
  input  logic                  i_start,
  input  logic                  i_word_valid,
  input  logic [WORD_WIDTH-1:0] i_word,
  output logic                  o_word_ready,
  output logic                  o_busy,
  output logic                  o_err_valid,
  input  logic                  i_err_ready,
  output logic [AW-1:0]         o_err_addr,
  output logic [DW-1:0]         o_err_data,
  output logic [AW:0]           o_err_count,
  output logic                  o_done
);

  state_t state;
  state_t state_nx;

  logic [AW-1:0]         wr_cnt;
  logic [AW-1:0]         rd_cnt;
  logic                  xfer;
  logic                  wr_last;
  logic                  rd_last;
  logic                  flagged;
  logic                  ram_en;
  logic                  ram_we;
  logic                  ram_re;
  logic [AW-1:0]         ram_addr;
  logic [WORD_WIDTH-1:0] ram_rdata;

  assign xfer    = (state == CAPTURE) && i_word_valid;
  assign wr_last = (wr_cnt == LAST_IDX);
  assign rd_last = (rd_cnt == LAST_IDX);
  assign flagged = ram_rdata[ERR_BIT];

  // State and datapath registers advance together.
  always_ff @(posedge i_clk_top or posedge i_rst_top) begin
    if (i_rst_top) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      o_err_count <= '0;
      o_err_valid <= 1'b0;
      o_err_addr  <= '0;
      o_err_data  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            wr_cnt      <= '0;
            o_err_count <= '0;
          end
        end
        CAPTURE: begin
          if (xfer) begin
            wr_cnt <= wr_cnt + AW'(1);
            if (i_word[ERR_BIT]) begin
              o_err_count <= o_err_count + (AW+1)'(1);
            end
            if (wr_last) begin
              rd_cnt <= '0;
            end
          end
        end
        RD_EVAL: begin
          if (flagged) begin
            o_err_addr  <= rd_cnt;
            o_err_data  <= ram_rdata[DW-1:0];
            o_err_valid <= 1'b1;
          end else if (!rd_last) begin
            rd_cnt <= rd_cnt + AW'(1);
          end
        end
        REPORT: begin
          if (o_err_valid && i_err_ready) begin
            o_err_valid <= 1'b0;
            if (!rd_last) begin
              rd_cnt <= rd_cnt + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_start) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (xfer && wr_last) state_nx = RD_ISSUE;
      end
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  state_nx = RD_EVAL;
      RD_EVAL: begin
        if (flagged)      state_nx = REPORT;
        else if (rd_last) state_nx = DONE;
        else              state_nx = RD_ISSUE;
      end
      REPORT: begin
        if (o_err_valid && i_err_ready) begin
          state_nx = rd_last ? DONE : RD_ISSUE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_word_ready = 1'b0;
    o_busy       = (state != IDLE);
    o_done       = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = rd_cnt;
    unique case (state)
      CAPTURE: begin
        o_word_ready = 1'b1;
        ram_en       = xfer;
        ram_we       = xfer;
        ram_addr     = wr_cnt;
      end
      RD_ISSUE: begin
        ram_en = 1'b1;
        ram_re = 1'b1;
      end
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  result_collector_ram #(
    .DATA_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk   (i_clk_top),
    .wdata (i_word),
    .addr  (ram_addr),
    .en    (ram_en),
    .we    (ram_we),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a frame-level model
// checked every cycle plus hand-computed expectations.
module tb_result_collector;
  import result_collector_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  wv;
  logic [WORD_WIDTH-1:0] word;
  logic                  er;
  logic                  o_word_ready;
  logic                  o_busy;
  logic                  o_err_valid;
  logic [AW-1:0]         o_err_addr;
  logic [DW-1:0]         o_err_data;
  logic [AW:0]           o_err_count;
  logic                  o_done;

  result_collector dut (
    .i_clk_top    (clk),
    .i_rst_top    (rst),
    .i_start      (start),
    .i_word_valid (wv),
    .i_word       (word),
    .o_word_ready (o_word_ready),
    .o_busy       (o_busy),
    .o_err_valid  (o_err_valid),
    .i_err_ready  (er),
    .o_err_addr   (o_err_addr),
    .o_err_data   (o_err_data),
    .o_err_count  (o_err_count),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Frame model: 0 idle, 1 capturing, 2 reading back.
  int                    ph = 0;
  logic [WORD_WIDTH-1:0] mw [RAM_DEPTH];
  int                    mn = 0;
  int                    mcnt = 0;
  int                    exp_a [$];
  int                    exp_d [$];
  int                    cyc = 0;
  int                    last_x = 0;
  int                    done_cyc = 0;
  int                    done_n = 0;
  int                    rep_n = 0;
  int                    rep_a [64];
  int                    rep_d [64];
  int                    hold_cnt = 0;
  logic                  pv = 1'b0;
  logic                  pr = 1'b0;
  logic [AW-1:0]         pa = '0;
  logic [DW-1:0]         pd = '0;

  logic [WORD_WIDTH-1:0] fw [RAM_DEPTH];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        ph = 0;
        mn = 0;
        mcnt = 0;
        exp_a.delete();
        exp_d.delete();
        pv = 1'b0;
        pr = 1'b0;
        continue;
      end
      chk("word_ready", o_word_ready, ph == 1);
      chk("busy", o_busy, ph != 0);
      chk("err_count", o_err_count, mcnt);
      if (ph != 2) chk("err_valid_quiet", o_err_valid, 0);
      if (pv && !pr) begin
        chk("hold_valid", o_err_valid, 1);
        chk("hold_addr", o_err_addr, pa);
        chk("hold_data", o_err_data, pd);
        hold_cnt++;
      end else if (pv && pr) begin
        chk("valid_drop", o_err_valid, 0);
      end
      if (o_err_valid && er) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_report: addr %0d data %0d, required none",
                   o_err_addr, o_err_data);
        end else begin
          chk("rep_addr", o_err_addr, exp_a.pop_front());
          chk("rep_data", o_err_data, exp_d.pop_front());
        end
        if (rep_n < 64) begin
          rep_a[rep_n] = int'(o_err_addr);
          rep_d[rep_n] = int'(o_err_data);
        end
        rep_n++;
      end
      if (o_done) begin
        chk("done_phase", ph, 2);
        chk("done_pending", exp_a.size(), 0);
        done_cyc = cyc;
        done_n++;
      end
      pv = o_err_valid;
      pr = er;
      pa = o_err_addr;
      pd = o_err_data;
      case (ph)
        0: if (start) begin
          ph = 1;
          mn = 0;
          mcnt = 0;
        end
        1: if (wv) begin
          mw[mn] = word;
          if (word[ERR_BIT]) mcnt++;
          last_x = cyc;
          mn++;
          if (mn == RAM_DEPTH) begin
            ph = 2;
            for (int a = 0; a < RAM_DEPTH; a++) begin
              if (mw[a][ERR_BIT]) begin
                exp_a.push_back(a);
                exp_d.push_back(int'(mw[a][DW-1:0]));
              end
            end
          end
        end
        2: if (o_done) ph = 0;
        default: ph = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start with a stray valid word that must be dropped in IDLE.
  task automatic do_start();
    start = 1'b1;
    wv    = 1'b1;
    word  = 7'h7F;
    tick();
    start = 1'b0;
    wv    = 1'b0;
  endtask

  task automatic send(input bit gap);
    for (int i = 0; i < RAM_DEPTH; i++) begin
      wv   = 1'b1;
      word = fw[i];
      tick();
      if (gap) begin
        wv = 1'b0;
        tick();
      end
    end
    wv = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = done_n;
    k  = 0;
    while (done_n == n0 && k < budget) begin
      tick();
      k++;
    end
    chk("done_seen", done_n > n0, 1);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!o_err_valid && k < budget) begin
      tick();
      k++;
    end
    chk("report_seen", o_err_valid, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, o_word_ready, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_valid"}, o_err_valid, 0);
    chk({nm, "_addr"}, o_err_addr, 0);
    chk({nm, "_data"}, o_err_data, 0);
    chk({nm, "_count"}, o_err_count, 0);
    chk({nm, "_done"}, o_done, 0);
  endtask

  initial begin
    int b;
    int h0;
    rst   = 1'b1;
    start = 1'b0;
    wv    = 1'b0;
    word  = '0;
    er    = 1'b1;
    fork
      monitor();
    join_none
    #7;
    chk_zero("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_ready", o_word_ready, 0);
    tick();

    // Clean frame: no reports, fixed readback latency.
    for (int i = 0; i < RAM_DEPTH; i++) fw[i] = 7'(i);
    do_start();
    b = rep_n;
    send(1'b0);
    wait_done(200);
    chk("clean_count", o_err_count, 0);
    chk("clean_reports", rep_n - b, 0);
    chk("clean_latency", done_cyc - last_x, 49);
    chk("clean_idle", o_busy, 0);

    // Two flagged words at indices 3 and 15.
    fw[3]  = 7'h45;
    fw[15] = 7'h7F;
    do_start();
    b = rep_n;
    send(1'b0);
    wait_done(200);
    chk("two_count", o_err_count, 2);
    chk("two_reports", rep_n - b, 2);
    chk("two_addr0", rep_a[b], 3);
    chk("two_data0", rep_d[b], 5);
    chk("two_addr1", rep_a[b+1], 15);
    chk("two_data1", rep_d[b+1], 63);

    // Same frame with back-pressure on the first report.
    er = 1'b0;
    do_start();
    b = rep_n;
    send(1'b0);
    wait_valid(200);
    chk("bp_first_addr", o_err_addr, 3);
    h0 = hold_cnt;
    repeat (10) tick();
    er = 1'b1;
    wait_done(200);
    chk("bp_hold_cycles", hold_cnt - h0, 10);
    chk("bp_reports", rep_n - b, 2);
    chk("bp_addr1", rep_a[b+1], 15);
    chk("bp_count", o_err_count, 2);

    // Sparse valid plus extra words after the frame is full.
    for (int i = 0; i < RAM_DEPTH; i++) begin
      fw[i] = (i % 5 == 0) ? 7'(8'h40 + i) : 7'(i);
    end
    do_start();
    b = rep_n;
    send(1'b1);
    repeat (5) begin
      wv   = 1'b1;
      word = 7'h7F;
      tick();
    end
    wv = 1'b0;
    wait_done(200);
    chk("gap_count", o_err_count, 4);
    chk("gap_reports", rep_n - b, 4);
    for (int k = 0; k < 4; k++) begin
      chk("gap_addr", rep_a[b+k], 5 * k);
      chk("gap_data", rep_d[b+k], 5 * k);
    end

    // All-flagged frame, reset while a report is pending.
    for (int i = 0; i < RAM_DEPTH; i++) fw[i] = 7'(8'h40 + i);
    er = 1'b0;
    do_start();
    send(1'b0);
    wait_valid(200);
    chk("full_count", o_err_count, 16);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    er  = 1'b1;
    for (int i = 0; i < RAM_DEPTH; i++) fw[i] = 7'(i + 32);
    do_start();
    b = rep_n;
    send(1'b0);
    wait_done(200);
    chk("fresh_count", o_err_count, 0);
    chk("fresh_reports", rep_n - b, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
